// File: rtl/shared_dmem_arbiter_pkg.sv
// Shared types and default sizes for the multi-core DMEM arbiter.
// The FSM encoding and the index-width helper live here so every block agrees on them.
package dmem_arb_pkg;

   localparam int DEF_NUM_CORES = 4;
   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_DATA_W    = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   // Width of a core index; a single core still needs one bit to name it.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shared_dmem_arbiter_rr_priority_picker.sv
// Round-robin picker: scans requests starting just after the last winner, wrapping,
// and reports the first requester found.
module rr_priority_picker
   import dmem_arb_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   localparam int IDX_W    = idx_w(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     last_winner,
   output logic [IDX_W-1:0]     winner,
   output logic                 valid
);

   logic [IDX_W-1:0] cand;

   // Walk from farthest to nearest so the nearest requester is written last and wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int i = NUM_CORES; i >= 1; i--) begin
         cand = IDX_W'((int'(last_winner) + i) % NUM_CORES);
         if (req[cand]) begin
            winner = cand;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_dmem_arbiter.sv
// Arbitrates several cores onto one single-ported DMEM: IDLE picks a winner, ACCESS
// issues it for one cycle, RESP returns read data one cycle later.
module shared_dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_wr,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_gnt,
   output logic [NUM_CORES-1:0]        core_rvalid,
   output logic [DATA_W-1:0]           core_rdata,
   output logic                        dmem_enable,
   output logic                        dmem_WR,
   output logic [ADDR_W-1:0]           write_address,
   output logic [DATA_W-1:0]           data,
   input  logic [DATA_W-1:0]           data_read,
   output logic                        busy
);

   localparam int IDX_W = idx_w(NUM_CORES);

   arb_state_t           state_q, state_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [NUM_CORES-1:0] gnt_q, gnt_d;
   logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
   logic                 en_q, en_d;
   logic                 wr_q, wr_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;

   logic [IDX_W-1:0]     pick;
   logic                 pick_valid;

   rr_priority_picker #(.NUM_CORES(NUM_CORES)) u_picker (
      .req         (core_req),
      .last_winner (last_q),
      .winner      (pick),
      .valid       (pick_valid)
   );

   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latch).
      state_d  = state_q;
      last_d   = last_q;
      gnt_d    = '0;
      rvalid_d = '0;
      en_d     = 1'b0;
      wr_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d     = ACCESS;
               last_d      = pick;
               gnt_d[pick] = 1'b1;
               en_d        = 1'b1;
               wr_d        = core_wr[pick];
               addr_d      = core_addr[int'(pick)*ADDR_W +: ADDR_W];
               wdata_d     = core_wdata[int'(pick)*DATA_W +: DATA_W];
            end
         end
         ACCESS: begin
            if (wr_q) begin
               state_d = IDLE;
            end else begin
               state_d          = RESP;
               rvalid_d[last_q] = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            rdata_d = data_read;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= IDX_W'(NUM_CORES - 1);
         gnt_q    <= '0;
         rvalid_q <= '0;
         en_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         en_q     <= en_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   // Reset masks the strobes in its own cycle, so an aborted access never issues or returns.
   assign core_gnt      = reset ? '0 : gnt_q;
   assign core_rvalid   = reset ? '0 : rvalid_q;
   assign dmem_enable   = en_q & ~reset;
   assign dmem_WR       = wr_q & ~reset;
   assign write_address = addr_q;
   assign data          = wdata_q;
   assign core_rdata    = (state_q == RESP && !reset) ? data_read : rdata_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Self-checking bench for shared_dmem_arbiter: DMEM model, grant/read scoreboards
// and one task per scenario.
module tb_shared_dmem_arbiter;

   localparam int NC = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [NC-1:0]    core_req;
   logic [NC-1:0]    core_wr;
   logic [NC*AW-1:0] core_addr;
   logic [NC*DW-1:0] core_wdata;
   logic [NC-1:0]    core_gnt;
   logic [NC-1:0]    core_rvalid;
   logic [DW-1:0]    core_rdata;
   logic             dmem_enable;
   logic             dmem_WR;
   logic [AW-1:0]    write_address;
   logic [DW-1:0]    data;
   logic [DW-1:0]    data_read;
   logic             busy;

   always #5 clk = ~clk;

   shared_dmem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk           (clk),
      .reset         (reset),
      .core_req      (core_req),
      .core_wr       (core_wr),
      .core_addr     (core_addr),
      .core_wdata    (core_wdata),
      .core_gnt      (core_gnt),
      .core_rvalid   (core_rvalid),
      .core_rdata    (core_rdata),
      .dmem_enable   (dmem_enable),
      .dmem_WR       (dmem_WR),
      .write_address (write_address),
      .data          (data),
      .data_read     (data_read),
      .busy          (busy)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          core;
      logic        wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } gnt_exp_t;

   typedef struct {
      int          core;
      logic [DW-1:0] data;
   } rd_exp_t;

   gnt_exp_t gnt_sb[$];
   rd_exp_t  rd_sb[$];

   logic [DW-1:0] mem [logic [AW-1:0]];

   // DMEM model: synchronous write, read data valid the cycle after the enabled read.
   always @(posedge clk) begin
      if (dmem_enable) begin
         if (dmem_WR) mem[write_address] = data;
         else data_read <= mem.exists(write_address) ? mem[write_address] : '0;
      end
   end

   // Scoreboard monitor: every grant and every rvalid must match the oldest expectation.
   always @(negedge clk) begin
      if (core_gnt !== '0) begin
         checks++;
         if (gnt_sb.size() == 0) begin
            errors++;
            $display("FAIL gnt_sb: unexpected gnt=%b", core_gnt);
         end else begin
            gnt_exp_t e;
            logic [NC-1:0] ev;
            e  = gnt_sb.pop_front();
            ev = NC'(1) << e.core;
            if (core_gnt !== ev || dmem_enable !== 1'b1 || dmem_WR !== e.wr ||
                write_address !== e.addr || (e.wr && data !== e.wdata)) begin
               errors++;
               $display("FAIL gnt_sb: got gnt=%b en=%b wr=%b addr=%h data=%h, need gnt=%b en=1 wr=%b addr=%h data=%h",
                        core_gnt, dmem_enable, dmem_WR, write_address, data, ev, e.wr, e.addr, e.wdata);
            end
         end
      end
      if (core_rvalid !== '0) begin
         checks++;
         if (rd_sb.size() == 0) begin
            errors++;
            $display("FAIL rd_sb: unexpected rvalid=%b rdata=%h", core_rvalid, core_rdata);
         end else begin
            rd_exp_t r;
            logic [NC-1:0] rv;
            r  = rd_sb.pop_front();
            rv = NC'(1) << r.core;
            if (core_rvalid !== rv || core_rdata !== r.data) begin
               errors++;
               $display("FAIL rd_sb: got rvalid=%b rdata=%h, need rvalid=%b rdata=%h",
                        core_rvalid, core_rdata, rv, r.data);
            end
         end
      end
   end

   task automatic set_core(input int c, input logic req, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      core_req[c]             = req;
      core_wr[c]              = wr;
      core_addr[c*AW +: AW]   = a;
      core_wdata[c*DW +: DW]  = d;
   endtask

   // Drive a request and record what the DUT must produce for it.
   task automatic issue(input int c, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] rd_exp);
      set_core(c, 1'b1, wr, a, d);
      gnt_sb.push_back('{core: c, wr: wr, addr: a, wdata: d});
      if (!wr) rd_sb.push_back('{core: c, data: rd_exp});
   endtask

   // Drop each request once granted; stop when everything is drained or the budget expires.
   task automatic run_until_idle(input int budget);
      int n;
      for (n = 0; n < budget; n++) begin
         @(negedge clk);
         core_req = core_req & ~core_gnt;
         if (core_req == '0 && busy == 1'b0 && gnt_sb.size() == 0 && rd_sb.size() == 0) break;
      end
      if (n == budget) begin
         errors++;
         $display("FAIL drain_timeout: got req=%b busy=%b pending=%0d, need idle within %0d cycles",
                  core_req, busy, gnt_sb.size() + rd_sb.size(), budget);
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      core_req   = '0;
      core_wr    = '0;
      core_addr  = '0;
      core_wdata = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({core_gnt, core_rvalid, dmem_enable, dmem_WR, busy} !== '0) begin
         errors++;
         $display("FAIL reset_strobes: got gnt=%b rvalid=%b en=%b wr=%b busy=%b, need all 0",
                  core_gnt, core_rvalid, dmem_enable, dmem_WR, busy);
      end
      checks++;
      if (write_address !== '0 || data !== '0 || core_rdata !== '0) begin
         errors++;
         $display("FAIL reset_buses: got addr=%h data=%h rdata=%h, need 0", write_address, data, core_rdata);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || core_gnt !== '0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b gnt=%b, need 0", busy, core_gnt);
      end
   endtask

   task automatic test_single_read();
      mem[32'h40] = 32'hDEADBEEF;
      issue(2, 1'b0, 32'h40, '0, 32'hDEADBEEF);
      @(negedge clk);
      checks++;
      if (core_gnt !== 4'b0100) begin
         errors++;
         $display("FAIL read_gnt_latency: got gnt=%b, need 0100", core_gnt);
      end
      core_req[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (core_rvalid !== 4'b0100 || core_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_rvalid_latency: got rvalid=%b rdata=%h, need 0100 deadbeef", core_rvalid, core_rdata);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || core_rdata !== 32'hDEADBEEF || core_rvalid !== '0) begin
         errors++;
         $display("FAIL read_rdata_hold: got busy=%b rvalid=%b rdata=%h, need 0 0 deadbeef",
                  busy, core_rvalid, core_rdata);
      end
   endtask

   task automatic test_single_write();
      issue(1, 1'b1, 32'h80, 32'h12345678, '0);
      @(negedge clk);
      checks++;
      if (core_gnt !== 4'b0010 || dmem_WR !== 1'b1) begin
         errors++;
         $display("FAIL write_gnt: got gnt=%b wr=%b, need 0010 1", core_gnt, dmem_WR);
      end
      core_req[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL write_busy: got busy=%b, need 0 one cycle after gnt", busy);
      end
      issue(1, 1'b0, 32'h80, '0, 32'h12345678);
      run_until_idle(10);
   endtask

   task automatic test_fairness();
      int g;
      reset = 1'b1;
      core_req = '0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NC; i++) mem[32'h100 + 32'(4*i)] = 32'hA000_0000 + 32'(i);
      for (int i = 0; i < NC; i++) set_core(i, 1'b1, 1'b0, 32'h100 + 32'(4*i), '0);
      for (int k = 0; k < 5; k++) begin
         gnt_sb.push_back('{core: k % NC, wr: 1'b0, addr: 32'h100 + 32'(4*(k % NC)), wdata: '0});
         rd_sb.push_back('{core: k % NC, data: 32'hA000_0000 + 32'(k % NC)});
      end
      g = 0;
      for (int n = 0; n < 40 && g < 5; n++) begin
         @(negedge clk);
         if (core_gnt !== '0) g++;
         if (g == 5) core_req = '0;
      end
      checks++;
      if (g != 5) begin
         errors++;
         $display("FAIL fairness_grants: got %0d grants, need 5 within 40 cycles", g);
         core_req = '0;
      end
      run_until_idle(20);
   endtask

   task automatic test_wrap();
      mem[32'h10C] = 32'hA000_0003;
      issue(3, 1'b1, 32'h200, 32'h55AA55AA, '0);
      run_until_idle(10);
      issue(1, 1'b0, 32'h80, '0, 32'h12345678);
      issue(3, 1'b0, 32'h200, '0, 32'h55AA55AA);
      @(negedge clk);
      checks++;
      if (core_gnt !== 4'b0010) begin
         errors++;
         $display("FAIL wrap_order: got gnt=%b, need 0010 after last winner 3", core_gnt);
      end
      core_req = core_req & ~core_gnt;
      run_until_idle(20);
   endtask

   task automatic test_reset_mid_read();
      set_core(2, 1'b1, 1'b0, 32'h40, '0);
      gnt_sb.push_back('{core: 2, wr: 1'b0, addr: 32'h40, wdata: '0});
      @(negedge clk);
      core_req[2] = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checks++;
      if (core_rvalid !== '0 || core_gnt !== '0) begin
         errors++;
         $display("FAIL reset_mid_read_rvalid: got rvalid=%b gnt=%b, need 0", core_rvalid, core_gnt);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || core_rdata !== '0) begin
         errors++;
         $display("FAIL reset_mid_read_state: got busy=%b rdata=%h, need 0 0", busy, core_rdata);
      end
      reset = 1'b0;
      issue(0, 1'b0, 32'h100, '0, 32'hA000_0000);
      issue(3, 1'b0, 32'h10C, '0, 32'hA000_0003);
      @(negedge clk);
      checks++;
      if (core_gnt !== 4'b0001) begin
         errors++;
         $display("FAIL reset_mid_read_priority: got gnt=%b, need 0001", core_gnt);
      end
      core_req = core_req & ~core_gnt;
      run_until_idle(20);
   endtask

   task automatic test_busy_request();
      issue(3, 1'b0, 32'h10C, '0, 32'hA000_0003);
      @(negedge clk);
      core_req[3] = 1'b0;
      @(negedge clk);
      checks++;
      if (core_rvalid !== 4'b1000) begin
         errors++;
         $display("FAIL busy_resp: got rvalid=%b, need 1000", core_rvalid);
      end
      issue(0, 1'b0, 32'h100, '0, 32'hA000_0000);
      @(negedge clk);
      checks++;
      if (core_gnt !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_idle_gap: got gnt=%b busy=%b, need 0000 0", core_gnt, busy);
      end
      @(negedge clk);
      checks++;
      if (core_gnt !== 4'b0001) begin
         errors++;
         $display("FAIL busy_late_gnt: got gnt=%b, need 0001 two cycles after RESP", core_gnt);
      end
      core_req[0] = 1'b0;
      run_until_idle(10);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_fairness();
      test_wrap();
      test_reset_mid_read();
      test_busy_request();
      checks++;
      if (gnt_sb.size() != 0 || rd_sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d grants and %0d reads outstanding, need 0",
                  gnt_sb.size(), rd_sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shared_dmem_arbiter.md
SHARED_DMEM_ARBITER -- requirements
Module: shared_dmem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, the number of requesting cores (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, the DMEM address width.
REQ-003 SHALL have parameter DATA_W, default 32, the DMEM data width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port core_req, input, NUM_CORES, the per-core access request.
REQ-007 SHALL have port core_wr, input, NUM_CORES, per-core 1=write, 0=read.
REQ-008 SHALL have port core_addr, input, NUM_CORES x ADDR_W, the per-core address.
REQ-009 SHALL have port core_wdata, input, NUM_CORES x DATA_W, the per-core write data.
REQ-010 SHALL have port core_gnt, output, NUM_CORES, one-hot, meaning the access is issued this cycle.
REQ-011 SHALL have port core_rvalid, output, NUM_CORES, one-hot, meaning read data is valid this cycle.
REQ-012 SHALL have port core_rdata, output, DATA_W, the shared read-data bus.
REQ-013 SHALL have port dmem_enable, output, 1, the DMEM enable.
REQ-014 SHALL have port dmem_WR, output, 1, the DMEM write strobe.
REQ-015 SHALL have port write_address, output, ADDR_W, the DMEM address.
REQ-016 SHALL have port data, output, DATA_W, the DMEM write data.
REQ-017 SHALL have port data_read, input, DATA_W, the DMEM read data, valid one cycle after the enabled read.
REQ-018 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-020 SHALL, in IDLE with any core_req bit set, pick one winner by round-robin and go to ACCESS next cycle; with no request it SHALL stay in IDLE.
REQ-021 SHALL search for the winner starting at index (last_winner+1) mod NUM_CORES, ascending and wrapping.
REQ-022 SHALL set last_winner to the winner on each grant.
REQ-023 SHALL, in ACCESS, drive core_gnt[winner]=1, dmem_enable=1, dmem_WR=core_wr[winner], and drive write_address and data from the winner's live inputs, for exactly one cycle.
REQ-024 SHALL, from ACCESS, go to IDLE for a write and to RESP for a read.
REQ-025 SHALL, in RESP, drive core_rdata=data_read and core_rvalid[winner]=1 for one cycle, then go to IDLE.
REQ-026 SHALL give a latency from req seen in IDLE to gnt of 1 cycle, and from gnt to rvalid of 1 cycle.
REQ-027 SHALL occupy the DMEM for 2 cycles per write and 3 cycles per read.
REQ-028 SHALL sample core_req only in IDLE; a core SHALL hold req, wr, addr and wdata stable until its gnt.
REQ-029 SHALL still perform the access if the winner drops req during ACCESS.
REQ-030 SHALL, on simultaneous requests, grant every requester exactly once within NUM_CORES consecutive grants (no starvation).
REQ-031 SHALL hold dmem_enable, dmem_WR, core_gnt and core_rvalid at 0 outside the states named above; core_rdata SHALL hold its last value.

Reset
REQ-032 SHALL, on reset, set state=IDLE, last_winner=NUM_CORES-1 (core 0 first), and set core_gnt, core_rvalid, core_rdata, dmem_enable, dmem_WR, write_address, data and busy to 0.
REQ-033 SHALL, on reset during ACCESS or RESP, abort the transaction: no rvalid is produced and there is no grant in the reset cycle.
REQ-034 SHALL give reset priority over every request on the same edge.

Structure
REQ-035 SHALL place the arb_state_t enum (IDLE, ACCESS, RESP) and the default widths in the shared package dmem_arb_pkg.
REQ-036 SHALL implement the rotate-and-priority-encode as the sub-module rr_priority_picker (inputs req vector and last_winner; outputs winner index and valid).

Verification
REQ-037 SHALL verify a single read: core 2 reads addr 0x40 with DMEM[0x40]=0xDEADBEEF -> gnt[2] in cycle 1, rvalid[2] with rdata=0xDEADBEEF in cycle 2.
REQ-038 SHALL verify a single write: core 1 writes 0x12345678 to 0x80 -> dmem_WR=1 in the gnt cycle, busy low in the next cycle, and a later read returns 0x12345678.
REQ-039 SHALL verify all-requesting fairness: all 4 cores hold reads after reset -> grant order 0,1,2,3,0.
REQ-040 SHALL verify wrap-around: last_winner=3 with requests from cores 1 and 3 -> core 1 is granted next.
REQ-041 SHALL verify reset mid-read: reset asserted in the RESP cycle -> core_rvalid=0, state IDLE, and core 0 has priority afterwards.
REQ-042 SHALL verify a request during busy: core 0 requests while core 3's read is in RESP -> core 0 is granted 2 cycles after the RESP cycle (IDLE, then ACCESS).
